pixel_stream_sequencer: RTL

//  Upstream feeder for the bank of per-column 3x3 kernel units.
//  - Reads an NxN image from synchronous image RAM, one pixel per two clocks, in raster order.
//  - Broadcasts {address, pixel, we} on the shared kernel bus. Each value is held 2 clocks because kernel units act on alternate edges.
//  - Then performs a we=0 read-back sweep and strobes a downstream collector.

---
 rtl/pixel_stream_sequencer_pkg.sv | 22 ++
 rtl/pixel_stream_sequencer_if.sv | 39 +++
 rtl/pixel_stream_sequencer_slot_counter.sv | 44 ++++
 rtl/pixel_stream_sequencer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/pixel_stream_sequencer_pkg.sv
// Shared types and geometry for the pixel stream sequencer.
// Frame size, address width and the FSM state encoding live here so every file agrees.
package skel_pkg;

  localparam int N           = 8;
  localparam int BIT_SIZE    = 6;
  localparam int PIXEL_WIDTH = 8;
  localparam int ADDR_W      = BIT_SIZE + 1;
  localparam int FRAME_PIX   = N * N;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRIME0,
    PRIME1,
    BCAST,
    DRAIN,
    DONE
  } seq_state_e;

endpackage

// File: rtl/pixel_stream_sequencer_if.sv
// Control, image RAM, kernel bus and read-back signals of the sequencer.
// The stall input exists only when SEQ_STALL_EN is defined.
interface pixel_stream_sequencer_if;
  import skel_pkg::*;

  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   mem_rd_en;
  logic [ADDR_W-1:0]      mem_addr;
  logic [PIXEL_WIDTH-1:0] mem_rd_data;
  logic                   kern_we;
  logic [ADDR_W-1:0]      kern_addr;
  logic [PIXEL_WIDTH-1:0] kern_data;
  logic                   rb_valid;
  logic [ADDR_W-1:0]      rb_addr;
`ifdef SEQ_STALL_EN
  logic                   stall;
`endif

  modport master (
`ifdef SEQ_STALL_EN
    input  stall,
`endif
    input  start, mem_rd_data,
    output busy, done, mem_rd_en, mem_addr,
    output kern_we, kern_addr, kern_data, rb_valid, rb_addr
  );

  modport slave (
`ifdef SEQ_STALL_EN
    output stall,
`endif
    output start, mem_rd_data,
    input  busy, done, mem_rd_en, mem_addr,
    input  kern_we, kern_addr, kern_data, rb_valid, rb_addr
  );

endinterface

// File: rtl/pixel_stream_sequencer_slot_counter.sv
// Two-clock slot bit plus pixel index; last flags slot1 of the final pixel.
module seq_slot_counter
  import skel_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic              hold_i,
  output logic              slot_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic              slot_q, slot_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    slot_d = slot_q;
    addr_d = addr_q;
    if (clear_i) begin
      slot_d = 1'b0;
      addr_d = '0;
    end else if (advance_i && !hold_i) begin
      slot_d = !slot_q;
      if (slot_q) addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= 1'b0;
      addr_q <= '0;
    end else begin
      slot_q <= slot_d;
      addr_q <= addr_d;
    end
  end

  assign slot_o = slot_q;
  assign addr_o = addr_q;
  assign last_o = slot_q && (addr_q == LAST_ADDR);

endmodule

// File: rtl/pixel_stream_sequencer.sv
// Streams an NxN image from RAM onto the kernel bus (2 clks/pixel), then sweeps a read-back pass.
// Optional SEQ_STALL_EN adds a stall input honoured at slot0 of BCAST/DRAIN.
module pixel_stream_sequencer
  import skel_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  pixel_stream_sequencer_if.master bus
);

  if (FRAME_PIX > 2**ADDR_W || N < 3) begin : g_cfg_err
    $error("pixel_stream_sequencer: N must be >= 3 and N*N must fit in ADDR_W bits");
  end

  seq_state_e             state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   kern_we_q, kern_we_d;
  logic [ADDR_W-1:0]      kern_addr_q, kern_addr_d;
  logic [PIXEL_WIDTH-1:0] kern_data_q, kern_data_d;

  logic              slot, last, in_seq, hold, stall_w;
  logic [ADDR_W-1:0] addr;

`ifdef SEQ_STALL_EN
  assign stall_w = bus.stall;
`else
  assign stall_w = 1'b0;
`endif

  assign in_seq = (state_q == BCAST) || (state_q == DRAIN);
  assign hold   = in_seq && !slot && stall_w;

  seq_slot_counter u_slot_counter (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (!in_seq || last),
    .advance_i (in_seq),
    .hold_i    (hold),
    .slot_o    (slot),
    .addr_o    (addr),
    .last_o    (last)
  );

  always_comb begin
    state_d       = state_q;
    kern_we_d     = kern_we_q;
    kern_addr_d   = kern_addr_q;
    kern_data_d   = kern_data_q;
    bus.mem_rd_en = 1'b0;
    bus.mem_addr  = '0;
    bus.rb_valid  = 1'b0;
    bus.rb_addr   = '0;

    case (state_q)
      IDLE: if (bus.start) state_d = PRIME0;
      PRIME0: begin
        bus.mem_rd_en = 1'b1;
        state_d       = PRIME1;
      end
      PRIME1: begin
        kern_data_d = bus.mem_rd_data;
        kern_addr_d = '0;
        kern_we_d   = 1'b1;
        state_d     = BCAST;
      end
      BCAST: begin
        // Prefetch p+1 in slot0 so its data lands exactly when slot1 retires p.
        if (!slot) begin
          if (!hold && addr != LAST_ADDR) begin
            bus.mem_rd_en = 1'b1;
            bus.mem_addr  = addr + ADDR_W'(1);
          end
        end else if (last) begin
          kern_we_d   = 1'b0;
          kern_addr_d = '0;
          state_d     = DRAIN;
        end else begin
          kern_addr_d = addr + ADDR_W'(1);
          kern_data_d = bus.mem_rd_data;
        end
      end
      DRAIN: begin
        if (slot) begin
          bus.rb_valid = 1'b1;
          bus.rb_addr  = kern_addr_q;
          if (last) begin
            kern_addr_d = '0;
            state_d     = DONE;
          end else begin
            kern_addr_d = addr + ADDR_W'(1);
          end
        end
      end
      DONE: begin
        kern_addr_d = '0;
        kern_data_d = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == PRIME0) || (state_d == PRIME1) ||
             (state_d == BCAST)  || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      kern_we_q   <= 1'b0;
      kern_addr_q <= '0;
      kern_data_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      kern_we_q   <= kern_we_d;
      kern_addr_q <= kern_addr_d;
      kern_data_q <= kern_data_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.kern_we   = kern_we_q;
  assign bus.kern_addr = kern_addr_q;
  assign bus.kern_data = kern_data_q;

endmodule
